// File: rtl/mem_port_arb.sv
// Two-requester arbiter for data memory read port 2 and the write port.
// Define MEM_ARB_RR_EN for burst-limited round robin; otherwise fixed CPU priority.
module mem_port_arb #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [10:0] req0_adrs,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [10:0] req1_adrs,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        mem_w_en,
  output logic [10:0] mem_w_adrs,
  output logic [31:0] mem_data_in,
  output logic        mem_r_en2,
  output logic [10:0] mem_r_adrs2,
  input  logic [31:0] mem_data_out2,
  input  logic        mem_r_valid2,
  input  logic        mem_w_valid1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [3:0] BURST = 4'(MAX_BURST);

  logic        pick1;
  logic        gnt0;
  logic        gnt1;
  logic        acc;
  logic        sel_we;
  logic [10:0] sel_adrs;
  logic [31:0] sel_wdata;
  logic        wr_go;
  logic        rd_go;
  logic [10:0] w_adrs_q;
  logic [31:0] wdata_q;
  logic [10:0] r_adrs_q;
  logic [1:0]  own;
  logic [1:0]  own_d;
  logic        was_wr;
  logic        rsp_fire;

`ifdef MEM_ARB_RR_EN
  logic       last;
  logic [3:0] cnt;

  // Stay with the current owner until its burst allowance is used up.
  assign pick1 = (cnt < BURST) ? last : ~last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last <= 1'b0;
      cnt  <= 4'd0;
    end else if (acc) begin
      if (gnt1 == last) begin
        if (cnt < BURST)
          cnt <= cnt + 4'd1;
      end else begin
        last <= gnt1;
        cnt  <= 4'd1;
      end
    end
  end
`else
  logic unused_cfg;

  assign pick1      = 1'b0;
  assign unused_cfg = ^BURST;
`endif

  // No grant while in reset so the memory only sees its own clear.
  assign gnt0 = resetn & req0_valid
              & (~req1_valid | ~pick1);
  assign gnt1 = resetn & req1_valid
              & (~req0_valid | pick1);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc        = gnt0 | gnt1;

  assign sel_we    = gnt1 ? req1_we    : req0_we;
  assign sel_adrs  = gnt1 ? req1_adrs  : req0_adrs;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;

  assign wr_go = acc & sel_we;
  assign rd_go = acc & ~sel_we;

  assign mem_w_en    = wr_go;
  assign mem_r_en2   = rd_go;
  assign mem_w_adrs  = wr_go ? sel_adrs  : w_adrs_q;
  assign mem_data_in = wr_go ? sel_wdata : wdata_q;
  assign mem_r_adrs2 = rd_go ? sel_adrs  : r_adrs_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_adrs_q <= 11'd0;
      wdata_q  <= 32'd0;
      r_adrs_q <= 11'd0;
    end else begin
      if (wr_go) begin
        w_adrs_q <= sel_adrs;
        wdata_q  <= sel_wdata;
      end
      if (rd_go)
        r_adrs_q <= sel_adrs;
    end
  end

  always_comb begin
    own_d = IDLE;
    unique case (1'b1)
      gnt0:    own_d = OWN0;
      gnt1:    own_d = OWN1;
      default: own_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      own    <= IDLE;
      was_wr <= 1'b0;
    end else begin
      own    <= own_d;
      was_wr <= wr_go;
    end
  end

  assign rsp_fire = mem_r_valid2 | mem_w_valid1;

  assign rsp0_valid = (own == OWN0) & rsp_fire;
  assign rsp1_valid = (own == OWN1) & rsp_fire;

  assign rsp0_rdata = (own == OWN0 && !was_wr)
                    ? mem_data_out2 : 32'd0;
  assign rsp1_rdata = (own == OWN1 && !was_wr)
                    ? mem_data_out2 : 32'd0;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a 2048x32 memory model.
// Expected grant pattern follows MEM_ARB_RR_EN.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req0_we;
  logic [10:0] req0_adrs;
  logic [31:0] req0_wdata;
  logic        req0_ready;
  logic        req1_valid, req1_we;
  logic [10:0] req1_adrs;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_w_en, mem_r_en2;
  logic [10:0] mem_w_adrs, mem_r_adrs2;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out2;
  logic        mem_r_valid2, mem_w_valid1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.MAX_BURST(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_we(req0_we),
    .req0_adrs(req0_adrs), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we),
    .req1_adrs(req1_adrs), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_w_en(mem_w_en), .mem_w_adrs(mem_w_adrs),
    .mem_data_in(mem_data_in),
    .mem_r_en2(mem_r_en2), .mem_r_adrs2(mem_r_adrs2),
    .mem_data_out2(mem_data_out2),
    .mem_r_valid2(mem_r_valid2),
    .mem_w_valid1(mem_w_valid1)
  );

  // Memory model: clears while in reset, registered read, one-cycle flags.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
      mem_data_out2 <= 32'd0;
      mem_r_valid2  <= 1'b0;
      mem_w_valid1  <= 1'b0;
    end else begin
      mem_r_valid2 <= mem_r_en2;
      mem_w_valid1 <= mem_w_en;
      if (mem_w_en) mem[mem_w_adrs] <= mem_data_in;
      if (mem_r_en2) mem_data_out2 <= mem[mem_r_adrs2];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  int g [10];

  initial begin
`ifdef MEM_ARB_RR_EN
    g = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
`else
    g = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    resetn     = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0;
    req0_adrs  = 11'h010; req0_wdata = 32'h1111_1111;
    req1_valid = 1'b1; req1_we = 1'b1;
    req1_adrs  = 11'h020; req1_wdata = 32'h2222_2222;

    // Reset held with both valid
    next(); next(); next();
    mid();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_rsp0v", rsp0_valid, 0);
    chk("rst_rsp1v", rsp1_valid, 0);
    chk("rst_rd0", rsp0_rdata, 0);
    chk("rst_rd1", rsp1_rdata, 0);
    chk("rst_wen", mem_w_en, 0);
    chk("rst_ren", mem_r_en2, 0);
    chk("rst_wadr", mem_w_adrs, 0);
    chk("rst_radr", mem_r_adrs2, 0);
    chk("rst_wdat", mem_data_in, 0);

    // Release: req0 read @0x010 granted in first cycle
    next();
    resetn = 1'b1; req1_valid = 1'b0;
    mid();
    chk("rel_rdy0", req0_ready, 1);
    chk("rel_ren", mem_r_en2, 1);
    chk("rel_radr", mem_r_adrs2, 32'h010);

    // req1 write DEADBEEF @7FF, rsp0 for the read
    next();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b1;
    req1_adrs  = 11'h7FF; req1_wdata = 32'hDEAD_BEEF;
    mid();
    chk("rel_rsp0v", rsp0_valid, 1);
    chk("rel_rsp0d", rsp0_rdata, 0);
    chk("w1_rdy1", req1_ready, 1);
    chk("w1_wen", mem_w_en, 1);
    chk("w1_wadr", mem_w_adrs, 32'h7FF);
    chk("w1_wdat", mem_data_in, 32'hDEAD_BEEF);

    // req1 read back @7FF
    next();
    req1_we = 1'b0;
    mid();
    chk("r1_rdy1", req1_ready, 1);
    chk("r1_ren", mem_r_en2, 1);
    chk("r1_wadr_hold", mem_w_adrs, 32'h7FF);
    chk("w1_rsp1v", rsp1_valid, 1);
    chk("w1_rsp1d", rsp1_rdata, 0);
    chk("w1_rsp0v", rsp0_valid, 0);

    next();
    req1_valid = 1'b0;
    mid();
    chk("r1_rsp1v", rsp1_valid, 1);
    chk("r1_rsp1d", rsp1_rdata, 32'hDEAD_BEEF);
    chk("r1_rsp0v", rsp0_valid, 0);
    chk("idle_wen", mem_w_en, 0);
    chk("idle_ren", mem_r_en2, 0);

    // Reset one cycle after a read accept
    next();
    req1_valid = 1'b1; req1_we = 1'b0; req1_adrs = 11'h7FF;
    mid();
    chk("mr_rdy1", req1_ready, 1);
    next();
    resetn = 1'b0; req1_valid = 1'b0;
    mid();
    chk("mr_rsp1v", rsp1_valid, 0);
    chk("mr_rsp0v", rsp0_valid, 0);
    chk("mr_ren", mem_r_en2, 0);
    chk("mr_radr", mem_r_adrs2, 0);
    next();
    mid();
    chk("mr_rsp1v2", rsp1_valid, 0);
    next();

    // Contention: both write continuously
    resetn     = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b1;
    req0_adrs  = 11'h100; req0_wdata = 32'hA5A5_0000;
    req1_valid = 1'b1; req1_we = 1'b1;
    req1_adrs  = 11'h200; req1_wdata = 32'h5A5A_0000;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk($sformatf("c%0d_rdy0", i), req0_ready, 32'(g[i] == 0));
      chk($sformatf("c%0d_rdy1", i), req1_ready, 32'(g[i] == 1));
      chk($sformatf("c%0d_wadr", i), mem_w_adrs,
          (g[i] == 1) ? 32'h200 : 32'h100);
      if (i > 0) begin
        chk($sformatf("c%0d_rsp0v", i), rsp0_valid, 32'(g[i-1] == 0));
        chk($sformatf("c%0d_rsp1v", i), rsp1_valid, 32'(g[i-1] == 1));
      end
      next();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    mid();
    chk("c_end_rsp0v", rsp0_valid, 1);
    chk("c_end_rsp1v", rsp1_valid, 0);
    chk("c_end_wen", mem_w_en, 0);

    // Write by req0, then read by req1 of the same word
    next();
    req0_valid = 1'b1; req0_we = 1'b1;
    req0_adrs  = 11'h100; req0_wdata = 32'h1234_5678;
    mid();
    chk("il_rdy0", req0_ready, 1);
    next();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_adrs = 11'h100;
    mid();
    chk("il_rdy1", req1_ready, 1);
    chk("il_radr", mem_r_adrs2, 32'h100);
    chk("il_rsp0v", rsp0_valid, 1);
    chk("il_rsp0d", rsp0_rdata, 0);
    next();
    req1_valid = 1'b0;
    mid();
    chk("il_rsp1v", rsp1_valid, 1);
    chk("il_rsp1d", rsp1_rdata, 32'h1234_5678);
    chk("il_wdat_hold", mem_data_in, 32'h1234_5678);
    chk("il_radr_hold", mem_r_adrs2, 32'h100);
    next();
    mid();
    chk("il_quiet", rsp1_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
